// File: rtl/tdm_audio_pkg.sv
// Shared definitions for the TDM/I2S audio master.
//   MODE_I2S / MODE_TDM : serial format selectors
//   clog2               : constant ceil(log2(v)), returns 0 for v <= 1
//   params_ok           : legality of a parameter set, used at elaboration
package tdm_audio_pkg;

    localparam int MODE_I2S = 0;
    localparam int MODE_TDM = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int num_ch, input int sample_w,
                                     input int slot_w, input int fifo_depth,
                                     input int bclk_half, input int mode);
        bit ok;
        ok = 1'b1;
        if (num_ch < 1 || num_ch > 8)                         ok = 1'b0;
        if (sample_w < 8 || sample_w > 32)                    ok = 1'b0;
        if (sample_w > slot_w)                                ok = 1'b0;
        if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
        if (bclk_half < 2)                                    ok = 1'b0;
        if (mode != MODE_I2S && mode != MODE_TDM)             ok = 1'b0;
        if (mode == MODE_I2S && num_ch != 2)                  ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Show-ahead synchronous frame FIFO.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write request and frame; ignored while full
//   pop          : drop the head frame; ignored while empty
//   rdata        : current head frame (valid while !empty)
//   full, empty  : occupancy flags; full is registered alongside level
//   level        : frames stored
module audio_frame_fifo
    import tdm_audio_pkg::*;
#(
    parameter int W     = 48,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10: begin
                    level <= level + 1'b1;
                    full  <= (level == LW'(DEPTH - 1));
                end
                2'b01: begin
                    level <= level - 1'b1;
                    full  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tdm_audio_master.sv
// Multi-channel audio serialiser: frame FIFO feeding an I2S or TDM output.
//   clk, reset      : clock, synchronous active-high reset
//   enable          : run the serial interface; low holds bclk/lrclk/sdata at 0
//   frame_in        : NUM_CH samples, ch0 in the low SAMPLE_W bits
//   write_frame     : push frame_in (dropped and flagged if full)
//   full, level     : FIFO occupancy
//   overflow        : sticky, write attempted while full
//   underrun_cnt    : saturating count of zero-substituted frames
//   status_clr      : clears overflow and underrun_cnt (wins over same-cycle events)
//   bclk, lrclk     : bit clock; word select (I2S) or one-bit frame sync (TDM)
//   sdata           : serial data, MSB first, one bclk behind lrclk
module tdm_audio_master
    import tdm_audio_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BCLK_HALF  = 16,
    parameter int MODE       = MODE_I2S
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_CH*SAMPLE_W-1:0]   frame_in,
    input  logic                         write_frame,
    output logic                         full,
    output logic [clog2(FIFO_DEPTH):0]   level,
    output logic                         overflow,
    output logic [15:0]                  underrun_cnt,
    input  logic                         status_clr,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         sdata
);

    localparam int FRAME_BITS = NUM_CH * SLOT_W;
    localparam int FW         = NUM_CH * SAMPLE_W;
    localparam int BW         = clog2(FRAME_BITS);
    localparam int DW         = clog2(BCLK_HALF);

    if (!params_ok(NUM_CH, SAMPLE_W, SLOT_W, FIFO_DEPTH, BCLK_HALF, MODE)) begin : g_param_error
        $error("tdm_audio_master: illegal parameter combination");
    end

    logic                  running;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_val;
    logic [FW-1:0]         fifo_head;
    logic                  fifo_empty;

    logic          div_tc;
    logic          bclk_fall;
    logic          start;
    logic [BW-1:0] bit_next;
    logic          frame_load;
    logic          pop;
    logic          underrun_evt;

    audio_frame_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (write_frame),
        .pop   (pop),
        .wdata (frame_in),
        .rdata (fifo_head),
        .full  (full),
        .empty (fifo_empty),
        .level (level)
    );

    function automatic logic lr_for(input logic [BW-1:0] idx);
        if (MODE == MODE_TDM) return (idx == '0);
        return (int'(idx) >= SLOT_W) && (int'(idx) < 2 * SLOT_W);
    endfunction

    // The first enabled cycle stands in for the bclk fall that opens b=0.
    assign start        = enable && !running;
    assign div_tc       = (div_cnt == DW'(BCLK_HALF - 1));
    assign bclk_fall    = running && div_tc && bclk;
    assign bit_next     = (bit_idx == BW'(FRAME_BITS - 1)) ? '0 : bit_idx + 1'b1;
    assign frame_load   = start || (bclk_fall && bit_next == '0);
    assign pop          = frame_load && !fifo_empty;
    assign underrun_evt = frame_load && fifo_empty;

    // Each slot: sample MSB-aligned, zero padded; ch0 occupies the top slot.
    always_comb begin
        load_val = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            load_val[FRAME_BITS-1-ch*SLOT_W -: SAMPLE_W] = fifo_head[ch*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            running <= 1'b0;
            div_cnt <= '0;
            bit_idx <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            shreg   <= '0;
        end else if (start) begin
            running <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            bclk    <= 1'b0;
            lrclk   <= lr_for('0);
            sdata   <= 1'b0;
            shreg   <= fifo_empty ? '0 : load_val;
        end else if (div_tc) begin
            div_cnt <= '0;
            bclk    <= !bclk;
            if (bclk) begin
                // Capture the outgoing MSB before a frame boundary reload.
                bit_idx <= bit_next;
                sdata   <= shreg[FRAME_BITS-1];
                lrclk   <= lr_for(bit_next);
                if (bit_next == '0) shreg <= fifo_empty ? '0 : load_val;
                else                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || status_clr) begin
            overflow     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (write_frame && full) overflow <= 1'b1;
            if (underrun_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule
